// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - opcode/funct3 constants, ALU op codes and decode helper
// Purpose: shared definitions for the procsn32 ALU issue controller.
//   Instruction layout {f7[31:25],rs2[24:20],rs1[19:15],f3[14:12],rd[11:7],op[6:0]}.
//   decode() maps (opcode, funct3) to an ALU op plus a legal flag.
package alu_issue_ctrl_pkg;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 7;
    localparam int F3_LSB  = 12;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int F7_LSB  = 25;

    localparam logic [6:0] OPC_ADDSUB = 7'h01;
    localparam logic [6:0] OPC_SHIFT  = 7'h03;
    localparam logic [6:0] OPC_CMP    = 7'h07;
    localparam logic [6:0] OPC_LOGIC  = 7'h0F;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SUB  = 3'd1;
    localparam logic [2:0] F3_SLL  = 3'd0;
    localparam logic [2:0] F3_SRL  = 3'd1;
    localparam logic [2:0] F3_SRA  = 3'd2;
    localparam logic [2:0] F3_SLT  = 3'd0;
    localparam logic [2:0] F3_SLTU = 3'd1;
    localparam logic [2:0] F3_XOR  = 3'd0;
    localparam logic [2:0] F3_OR   = 3'd1;
    localparam logic [2:0] F3_AND  = 3'd2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef struct packed {
        logic    legal;
        alu_op_t op;
    } dec_t;

    function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3);
        dec_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        case (opc)
            OPC_ADDSUB: case (f3)
                F3_ADD:  d.op = ALU_ADD;
                F3_SUB:  d.op = ALU_SUB;
                default: d.legal = 1'b0;
            endcase
            OPC_SHIFT: case (f3)
                F3_SLL:  d.op = ALU_SLL;
                F3_SRL:  d.op = ALU_SRL;
                F3_SRA:  d.op = ALU_SRA;
                default: d.legal = 1'b0;
            endcase
            OPC_CMP: case (f3)
                F3_SLT:  d.op = ALU_SLT;
                F3_SLTU: d.op = ALU_SLTU;
                default: d.legal = 1'b0;
            endcase
            OPC_LOGIC: case (f3)
                F3_XOR:  d.op = ALU_XOR;
                F3_OR:   d.op = ALU_OR;
                F3_AND:  d.op = ALU_AND;
                default: d.legal = 1'b0;
            endcase
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - instruction intake, issue and write-back signal bundle
// Purpose: groups the instruction handshake, the issued ALU op and the write-back strobe.
//   master: instruction source / ALU + register-bank side (drives inst_valid, inst)
//   slave : the issue controller (drives inst_ready, iss_*, wb_*)
interface alu_issue_ctrl_if;
    import alu_issue_ctrl_pkg::*;

    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        iss_valid;
    alu_op_t     iss_op;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;

    modport master (
        output inst_valid, inst,
        input  inst_ready, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd, wb_valid, wb_rd
    );

    modport slave (
        input  inst_valid, inst,
        output inst_ready, iss_valid, iss_op, iss_rs1, iss_rs2, iss_rd, wb_valid, wb_rd
    );
endinterface

// File: rtl/alu_issue_ctrl_sync_fifo.sv
// rtl/alu_issue_ctrl_sync_fifo.sv - synchronous instruction FIFO with registered head
// Purpose: DEPTH x WIDTH FIFO; rdata is the stored head entry, valid while !empty.
// Ports: clock, reset_n (async, active-low), flush (sync clear, beats push),
//   push/wdata (ignored when full, even with a same-cycle pop), pop (ignored when empty),
//   rdata, full, empty.
module alu_issue_ctrl_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - in-order ALU issue controller with register scoreboard
// Purpose: buffers instructions, decodes the head, issues it when rs1/rs2/rd have no
//   write-back in flight, tracks the ALU_LAT-deep pipe and drives the write-back strobe.
// Ports: clock, reset_n (async, active-low), flush (sync FIFO discard),
//   bus (slave: inst_valid/inst_ready/inst in, iss_* and wb_* out),
//   ill_pulse (illegal head dropped), busy, issued_cnt, stall_cnt.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    alu_issue_ctrl_if.slave  bus,
    output logic             ill_pulse,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] stall_cnt
);
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [31:0]        head;
    dec_t               head_dec;
    logic [4:0]         head_rs1, head_rs2, head_rd;
    logic               hazard, iss_fire, stall;
    logic [31:0]        pend, pend_next;
    logic [ALU_LAT-1:0] pipe_v;
    logic [4:0]         pipe_rd [ALU_LAT];
    logic               wb_v;
    logic [4:0]         wb_r;
    logic               unused_f7;

    alu_issue_ctrl_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (bus.inst_valid),
        .pop     (fifo_pop),
        .wdata   (bus.inst),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_dec  = decode(head[OP_LSB +: 7], head[F3_LSB +: 3]);
    assign head_rs1  = head[RS1_LSB +: 5];
    assign head_rs2  = head[RS2_LSB +: 5];
    assign head_rd   = head[RD_LSB +: 5];
    assign unused_f7 = ^head[F7_LSB +: 7];

    // pend[rd] is part of the hazard so write-backs to one register stay ordered.
    assign hazard    = pend[head_rs1] | pend[head_rs2] | pend[head_rd];
    assign iss_fire  = !fifo_empty && head_dec.legal && !hazard && !flush;
    assign stall     = !fifo_empty && head_dec.legal && hazard && !flush;
    assign ill_pulse = !fifo_empty && !head_dec.legal && !flush;
    assign fifo_pop  = iss_fire || ill_pulse;

    assign bus.inst_ready = !fifo_full;
    assign bus.iss_valid  = iss_fire;
    assign bus.iss_op     = iss_fire ? head_dec.op : ALU_ADD;
    assign bus.iss_rs1    = iss_fire ? head_rs1 : 5'd0;
    assign bus.iss_rs2    = iss_fire ? head_rs2 : 5'd0;
    assign bus.iss_rd     = iss_fire ? head_rd  : 5'd0;

    // pipe_rd only ever holds a non-zero index for a real issue, so wb_rd idles at 0.
    assign wb_v         = pipe_v[ALU_LAT-1] && (pipe_rd[ALU_LAT-1] != 5'd0);
    assign wb_r         = pipe_rd[ALU_LAT-1];
    assign bus.wb_valid = wb_v;
    assign bus.wb_rd    = wb_r;

    assign busy = !fifo_empty || (|pipe_v);

    // Clear from write-back first, then set from issue, so a same-cycle set wins.
    always_comb begin
        pend_next = pend;
        if (wb_v) pend_next[wb_r] = 1'b0;
        if (iss_fire && head_rd != 5'd0) pend_next[head_rd] = 1'b1;
        pend_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend       <= '0;
            pipe_v     <= '0;
            issued_cnt <= '0;
            stall_cnt  <= '0;
            for (int i = 0; i < ALU_LAT; i++) pipe_rd[i] <= 5'd0;
        end else begin
            pend       <= pend_next;
            pipe_v[0]  <= iss_fire;
            pipe_rd[0] <= iss_fire ? head_rd : 5'd0;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_v[i]  <= pipe_v[i-1];
                pipe_rd[i] <= pipe_rd[i-1];
            end
            if (iss_fire) issued_cnt <= issued_cnt + CNT_W'(1);
            if (stall)    stall_cnt  <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 2;
    localparam int CNT_W   = 16;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             ill_pulse, busy;
    logic [CNT_W-1:0] issued_cnt, stall_cnt;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .bus        (bus),
        .ill_pulse  (ill_pulse),
        .busy       (busy),
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: FIFO as a queue, per-register "free from cycle" times,
    // and a queue of expected write-backs keyed by cycle number.
    typedef struct {int cyc; logic [4:0] rd;} wb_t;
    logic [31:0] mq[$];
    wb_t         wbq[$];
    int          ready_at[32];
    int          cyc = 0;
    int          last_iss = -1000;
    int          m_issued = 0;
    int          m_stall = 0;

    bit          e_ready, e_busy, e_wb, e_iss, e_ill;
    logic [4:0]  e_wb_rd, e_rs1, e_rs2, e_rd;
    int          e_op, e_issued, e_stall;

    function automatic logic [31:0] mk(input int o, input int f, input int rd, input int rs1, input int rs2);
        return {7'($urandom), 5'(rs2), 5'(rs1), 3'(f), 5'(rd), 7'(o)};
    endfunction

    // ALU op number from the opcode/funct3 table, -1 when illegal.
    function automatic int ref_op(input logic [6:0] o, input logic [2:0] f);
        if (o == 7'h01 && f <= 3'd1) return int'(f);
        if (o == 7'h03 && f <= 3'd2) return 2 + int'(f);
        if (o == 7'h07 && f <= 3'd1) return 5 + int'(f);
        if (o == 7'h0F && f <= 3'd2) return 7 + int'(f);
        return -1;
    endfunction

    function automatic bit reg_free(input logic [4:0] r);
        return (r == 5'd0) || (cyc >= ready_at[r]);
    endfunction

    function automatic logic [31:0] rand_inst();
        int k = $urandom_range(0, 11);
        int o, f;
        if (k < 2)       begin o = 1;  f = k;     end
        else if (k < 5)  begin o = 3;  f = k - 2; end
        else if (k < 7)  begin o = 7;  f = k - 5; end
        else if (k < 10) begin o = 15; f = k - 7; end
        else if (k == 10) begin o = $urandom_range(0, 127); f = $urandom_range(0, 7); end
        else             begin o = 3;  f = 3;     end
        return mk(o, f, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    endfunction

    task automatic model_reset();
        mq.delete();
        wbq.delete();
        foreach (ready_at[i]) ready_at[i] = 0;
        last_iss = -1000;
        m_issued = 0;
        m_stall  = 0;
    endtask

    // Applies one cycle of inputs at the falling edge and derives the expected
    // outputs for that cycle from the model, then advances the model.
    task automatic drive(input int v, input logic [31:0] i, input int fl);
        logic [31:0] h;
        int op;
        @(negedge clock);
        bus.inst_valid = (v != 0);
        bus.inst       = i;
        flush          = (fl != 0);
        e_ready  = mq.size() < DEPTH;
        e_busy   = (mq.size() != 0) || (cyc > last_iss && cyc <= last_iss + ALU_LAT);
        e_issued = m_issued;
        e_stall  = m_stall;
        e_wb = 1'b0; e_wb_rd = 5'd0;
        if (wbq.size() != 0 && wbq[0].cyc == cyc) begin
            e_wb = 1'b1; e_wb_rd = wbq[0].rd;
            void'(wbq.pop_front());
        end
        e_iss = 1'b0; e_ill = 1'b0; e_op = 0; e_rs1 = 5'd0; e_rs2 = 5'd0; e_rd = 5'd0;
        if (fl == 0 && mq.size() != 0) begin
            h  = mq[0];
            op = ref_op(h[6:0], h[14:12]);
            if (op < 0) begin
                e_ill = 1'b1;
                void'(mq.pop_front());
            end else if (reg_free(h[19:15]) && reg_free(h[24:20]) && reg_free(h[11:7])) begin
                e_iss = 1'b1; e_op = op;
                e_rs1 = h[19:15]; e_rs2 = h[24:20]; e_rd = h[11:7];
                void'(mq.pop_front());
                m_issued++;
                last_iss = cyc;
                if (e_rd != 5'd0) begin
                    ready_at[e_rd] = cyc + ALU_LAT + 1;
                    wbq.push_back('{cyc + ALU_LAT, e_rd});
                end
            end else begin
                m_stall++;
            end
        end
        if (fl != 0) mq.delete();
        else if (v != 0 && e_ready) mq.push_back(i);
        cyc++;
        #1;
    endtask

    task automatic drain();
        repeat (ALU_LAT + 3) drive(0, 32'd0, 0);
    endtask

    task automatic test_reset();
        bus.inst_valid = 1'b1;
        bus.inst = mk(1, 0, 3, 1, 2);
        repeat (3) begin
            @(negedge clock); #1;
            n_cmp++;
            if (bus.inst_ready !== 1'b1 || bus.iss_valid !== 1'b0 || bus.wb_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: ready=%b iss=%b wb=%b busy=%b, want 1 0 0 0", bus.inst_ready, bus.iss_valid, bus.wb_valid, busy);
            end
            n_cmp++;
            if (issued_cnt !== '0 || stall_cnt !== '0) begin
                n_fail++;
                $display("FAIL reset_counters: issued=%0d stall=%0d, want 0 0", issued_cnt, stall_cnt);
            end
        end
        @(negedge clock);
        bus.inst_valid = 1'b0;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_back_to_back();
        int bi = m_issued, bs = m_stall;
        drive(1, mk(1, 0, 10, 1, 2), 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: iss_valid=%b want 0", bus.iss_valid); end
        drive(1, mk(1, 1, 11, 1, 2), 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1 || bus.iss_op !== 4'd0 || bus.iss_rd !== 5'd10 || bus.iss_rs1 !== 5'd1 || bus.iss_rs2 !== 5'd2) begin
            n_fail++; $display("FAIL b2b_add: v=%b op=%0d rd=%0d rs1=%0d rs2=%0d want 1 0 10 1 2", bus.iss_valid, bus.iss_op, bus.iss_rd, bus.iss_rs1, bus.iss_rs2);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1 || bus.iss_op !== 4'd1 || bus.iss_rd !== 5'd11) begin
            n_fail++; $display("FAIL b2b_sub: v=%b op=%0d rd=%0d want 1 1 11", bus.iss_valid, bus.iss_op, bus.iss_rd);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd10 || bus.iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_wb10: wb=%b rd=%0d iss=%b want 1 10 0", bus.wb_valid, bus.wb_rd, bus.iss_valid);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd11) begin
            n_fail++; $display("FAIL b2b_wb11: wb=%b rd=%0d want 1 11", bus.wb_valid, bus.wb_rd);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (issued_cnt !== CNT_W'(bi + 2) || stall_cnt !== CNT_W'(bs)) begin
            n_fail++; $display("FAIL b2b_counts: issued=%0d stall=%0d want %0d %0d", issued_cnt, stall_cnt, bi + 2, bs);
        end
        drain();
    endtask

    task automatic test_raw_hazard();
        int bs = m_stall;
        drive(1, mk(1, 0, 10, 1, 2), 0);
        drive(1, mk(15, 0, 17, 10, 2), 0);
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b0) begin n_fail++; $display("FAIL raw_hold1: iss_valid=%b want 0", bus.iss_valid); end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd10) begin
            n_fail++; $display("FAIL raw_hold2: iss=%b wb=%b rd=%0d want 0 1 10", bus.iss_valid, bus.wb_valid, bus.wb_rd);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1 || bus.iss_op !== 4'd7 || bus.iss_rd !== 5'd17 || bus.iss_rs1 !== 5'd10) begin
            n_fail++; $display("FAIL raw_issue: v=%b op=%0d rd=%0d rs1=%0d want 1 7 17 10", bus.iss_valid, bus.iss_op, bus.iss_rd, bus.iss_rs1);
        end
        drive(0, 32'd0, 0);
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd17) begin
            n_fail++; $display("FAIL raw_wb17: wb=%b rd=%0d want 1 17", bus.wb_valid, bus.wb_rd);
        end
        n_cmp++;
        if (stall_cnt !== CNT_W'(bs + 2)) begin n_fail++; $display("FAIL raw_stalls: stall=%0d want %0d", stall_cnt, bs + 2); end
        drain();
    endtask

    task automatic test_illegal();
        int bi = m_issued;
        drive(1, 32'h0000307F, 0);
        drive(1, mk(3, 3, 9, 1, 2), 0);
        n_cmp++;
        if (ill_pulse !== 1'b1 || bus.iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL ill_first: ill=%b iss=%b want 1 0", ill_pulse, bus.iss_valid);
        end
        drive(1, mk(3, 0, 12, 3, 4), 0);
        n_cmp++;
        if (ill_pulse !== 1'b1 || bus.iss_valid !== 1'b0 || issued_cnt !== CNT_W'(bi)) begin
            n_fail++; $display("FAIL ill_second: ill=%b iss=%b issued=%0d want 1 0 %0d", ill_pulse, bus.iss_valid, issued_cnt, bi);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (ill_pulse !== 1'b0 || bus.iss_valid !== 1'b1 || bus.iss_op !== 4'd2 || bus.iss_rd !== 5'd12) begin
            n_fail++; $display("FAIL ill_then_sll: ill=%b v=%b op=%0d rd=%0d want 0 1 2 12", ill_pulse, bus.iss_valid, bus.iss_op, bus.iss_rd);
        end
        drain();
    endtask

    task automatic test_full_flush();
        int bi = m_issued, bs = m_stall;
        drive(1, mk(1, 0, 10, 1, 2), 0);
        drive(1, mk(15, 0, 17, 10, 2), 0);
        drive(1, mk(15, 1, 18, 17, 3), 0);
        drive(1, mk(15, 2, 19, 4, 5), 0);
        drive(1, mk(1, 0, 20, 5, 6), 0);
        drive(1, mk(1, 0, 21, 5, 6), 0);
        drive(1, mk(1, 1, 22, 5, 6), 0);
        n_cmp++;
        if (bus.inst_ready !== 1'b0 || bus.iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: ready=%b iss=%b want 0 0", bus.inst_ready, bus.iss_valid);
        end
        drive(1, mk(1, 1, 22, 5, 6), 0);
        n_cmp++;
        if (bus.inst_ready !== 1'b0 || bus.iss_valid !== 1'b1 || bus.iss_rd !== 5'd18) begin
            n_fail++; $display("FAIL full_pop_push: ready=%b iss=%b rd=%0d want 0 1 18", bus.inst_ready, bus.iss_valid, bus.iss_rd);
        end
        drive(1, mk(1, 1, 22, 5, 6), 1);
        n_cmp++;
        if (bus.iss_valid !== 1'b0 || bus.inst_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_cycle: iss=%b ready=%b want 0 1", bus.iss_valid, bus.inst_ready);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd18 || busy !== 1'b1 || bus.iss_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_wb: wb=%b rd=%0d busy=%b iss=%b want 1 18 1 0", bus.wb_valid, bus.wb_rd, busy, bus.iss_valid);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (busy !== 1'b0 || bus.iss_valid !== 1'b0 || bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_idle: busy=%b iss=%b wb=%b want 0 0 0", busy, bus.iss_valid, bus.wb_valid);
        end
        n_cmp++;
        if (issued_cnt !== CNT_W'(bi + 3) || stall_cnt !== CNT_W'(bs + 4)) begin
            n_fail++; $display("FAIL flush_counts: issued=%0d stall=%0d want %0d %0d", issued_cnt, stall_cnt, bi + 3, bs + 4);
        end
        drain();
    endtask

    task automatic test_rd_zero();
        drive(1, mk(1, 0, 0, 1, 2), 0);
        drive(1, mk(1, 1, 5, 0, 0), 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1 || bus.iss_rd !== 5'd0) begin
            n_fail++; $display("FAIL r0_issue: v=%b rd=%0d want 1 0", bus.iss_valid, bus.iss_rd);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1 || bus.iss_op !== 4'd1 || bus.iss_rd !== 5'd5) begin
            n_fail++; $display("FAIL r0_reader: v=%b op=%0d rd=%0d want 1 1 5", bus.iss_valid, bus.iss_op, bus.iss_rd);
        end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL r0_no_wb: wb_valid=%b want 0", bus.wb_valid); end
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5) begin
            n_fail++; $display("FAIL r0_wb5: wb=%b rd=%0d want 1 5", bus.wb_valid, bus.wb_rd);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1, mk(1, 0, 9, 1, 2), 0);
        drive(0, 32'd0, 0);
        n_cmp++;
        if (bus.iss_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: iss_valid=%b want 1", bus.iss_valid); end
        #1 reset_n = 1'b0;
        @(negedge clock); #1;
        n_cmp++;
        if (bus.wb_valid !== 1'b0 || busy !== 1'b0 || issued_cnt !== '0) begin
            n_fail++; $display("FAIL rstmid_clear: wb=%b busy=%b issued=%0d want 0 0 0", bus.wb_valid, busy, issued_cnt);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        repeat (3) begin
            drive(0, 32'd0, 0);
            n_cmp++;
            if (bus.wb_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped_wb: wb_valid=%b want 0", bus.wb_valid); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0) ? 1 : 0, rand_inst(), ($urandom_range(0, 31) == 0) ? 1 : 0);
            n_cmp++;
            if (bus.inst_ready !== e_ready || busy !== e_busy || ill_pulse !== e_ill) begin
                n_fail++; $display("FAIL rnd_status cyc %0d: ready=%b busy=%b ill=%b want %b %b %b", n, bus.inst_ready, busy, ill_pulse, e_ready, e_busy, e_ill);
            end
            n_cmp++;
            if (bus.iss_valid !== e_iss) begin
                n_fail++; $display("FAIL rnd_iss_valid cyc %0d: %b want %b", n, bus.iss_valid, e_iss);
            end else if (e_iss) begin
                n_cmp++;
                if (bus.iss_op !== 4'(e_op) || bus.iss_rs1 !== e_rs1 || bus.iss_rs2 !== e_rs2 || bus.iss_rd !== e_rd) begin
                    n_fail++; $display("FAIL rnd_iss_fields cyc %0d: op=%0d rs1=%0d rs2=%0d rd=%0d want %0d %0d %0d %0d", n, bus.iss_op, bus.iss_rs1, bus.iss_rs2, bus.iss_rd, e_op, e_rs1, e_rs2, e_rd);
                end
            end
            n_cmp++;
            if (bus.wb_valid !== e_wb || (e_wb && bus.wb_rd !== e_wb_rd)) begin
                n_fail++; $display("FAIL rnd_wb cyc %0d: wb=%b rd=%0d want %b %0d", n, bus.wb_valid, bus.wb_rd, e_wb, e_wb_rd);
            end
            n_cmp++;
            if (issued_cnt !== CNT_W'(e_issued) || stall_cnt !== CNT_W'(e_stall)) begin
                n_fail++; $display("FAIL rnd_counts cyc %0d: issued=%0d stall=%0d want %0d %0d", n, issued_cnt, stall_cnt, e_issued, e_stall);
            end
        end
    endtask

    initial begin
        bus.inst_valid = 1'b0;
        bus.inst = 32'd0;
        test_reset();
        test_back_to_back();
        test_raw_hazard();
        test_illegal();
        test_full_flush();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
